// File: rtl/ahbl_multiport_checker_pkg.sv
// Shared AHB-Lite encodings and violation bit indices for the multiport protocol checker.
package ahbl_checker_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE = 2'b00,
    HTRANS_BUSY = 2'b01,
    HTRANS_NSEQ = 2'b10,
    HTRANS_SEQ  = 2'b11
  } htrans_e;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;

  localparam int W_ERR        = 8;
  localparam int ERR_HOLD     = 0;
  localparam int ERR_ALIGN    = 1;
  localparam int ERR_SIZE     = 2;
  localparam int ERR_BURST    = 3;
  localparam int ERR_RESP1    = 4;
  localparam int ERR_RESPX    = 5;
  localparam int ERR_STALL    = 6;
  localparam int ERR_IDLEWAIT = 7;

endpackage

// File: rtl/ahbl_multiport_checker_if.sv
// Packed N-port AHB-Lite bus bundle observed by the checker; port 0 sits in the LSBs of every field.
interface ahbl_multiport_checker_if #(
  parameter int N_PORTS = 2,
  parameter int W_ADDR  = 32
);
  logic [N_PORTS*W_ADDR-1:0] haddr;
  logic [N_PORTS-1:0]        hwrite;
  logic [N_PORTS*2-1:0]      htrans;
  logic [N_PORTS*3-1:0]      hsize;
  logic [N_PORTS*3-1:0]      hburst;
  logic [N_PORTS*4-1:0]      hprot;
  logic [N_PORTS-1:0]        hmastlock;
  logic [N_PORTS-1:0]        hready;
  logic [N_PORTS-1:0]        hresp;

  modport master (
    output haddr, hwrite, htrans, hsize, hburst, hprot, hmastlock, hready, hresp
  );

  modport slave (
    input haddr, hwrite, htrans, hsize, hburst, hprot, hmastlock, hready, hresp
  );
endinterface

// File: rtl/ahbl_multiport_checker_port.sv
// Single-port AHB-Lite monitor: history, data-phase tracking, sticky violation bits, transfer counter.
// Optional AHBL_CHECKER_FORMAL_EN adds immediate assert/assume of the violation bits under FORMAL.
module ahbl_port_checker
  import ahbl_checker_pkg::*;
#(
  parameter int W_ADDR        = 32,
  parameter int W_DATA        = 32,
  parameter int MAX_BUS_STALL = -1,
  parameter int W_CNT         = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [W_ADDR-1:0] haddr,
  input  logic              hwrite,
  input  logic [1:0]        htrans,
  input  logic [2:0]        hsize,
  input  logic [2:0]        hburst,
  input  logic [3:0]        hprot,
  input  logic              hmastlock,
  input  logic              hready,
  input  logic              hresp,
  output logic [W_ERR-1:0]  err_set,
  output logic [W_ERR-1:0]  err_flags,
  output logic [W_CNT-1:0]  xfer_count
);

  localparam int MAX_HSIZE = $clog2(W_DATA / 8);
  localparam int STALL_LIM = (MAX_BUS_STALL < 0) ? 1 : MAX_BUS_STALL + 1;
  localparam int W_STALL   = (STALL_LIM < 1) ? 1 : $clog2(STALL_LIM + 1);

  logic [1:0]        htrans_p1;
  logic [W_ADDR-1:0] haddr_p1;
  logic              hwrite_p1;
  logic [2:0]        hsize_p1;
  logic [2:0]        hburst_p1;
  logic [3:0]        hprot_p1;
  logic              hmastlock_p1;
  logic              hready_p1;
  logic              hresp_p1;

  logic               hist_vld;
  logic               dphase_vld;
  logic [W_STALL-1:0] stall_cnt;
  logic [W_STALL-1:0] stall_now;
  logic [W_ADDR-1:0]  addr_mask;
  logic               ctrl_diff;
  logic               resp2;
  logic               active;

  assign active = htrans[1];

  always_comb begin
    err_set   = '0;
    addr_mask = ~({W_ADDR{1'b1}} << hsize);
    resp2     = hresp_p1 && !hready_p1;
    ctrl_diff = (htrans != htrans_p1) || (haddr != haddr_p1) || (hwrite != hwrite_p1) ||
                (hsize != hsize_p1) || (hburst != hburst_p1) || (hprot != hprot_p1) ||
                (hmastlock != hmastlock_p1);
    stall_now = '0;
    if (dphase_vld && !hready)
      stall_now = (stall_cnt == '1) ? stall_cnt : stall_cnt + 1'b1;
    // history registers hold garbage until one clean cycle has passed since reset
    if (hist_vld) begin
      err_set[ERR_HOLD]     = htrans_p1[1] && !hready_p1 && ctrl_diff &&
                              !(resp2 && (htrans == HTRANS_IDLE));
      err_set[ERR_ALIGN]    = active && ((haddr & addr_mask) != '0);
      err_set[ERR_SIZE]     = active && (int'(hsize) > MAX_HSIZE);
      err_set[ERR_BURST]    = (((htrans == HTRANS_BUSY) || (htrans == HTRANS_SEQ)) &&
                               (hburst == HBURST_SINGLE)) ||
                              ((htrans == HTRANS_SEQ) && (htrans_p1 == HTRANS_IDLE));
      err_set[ERR_RESP1]    = resp2 && !(hresp && hready);
      err_set[ERR_RESPX]    = hresp && !dphase_vld;
      err_set[ERR_STALL]    = (MAX_BUS_STALL >= 0) && (int'(stall_now) > MAX_BUS_STALL);
      err_set[ERR_IDLEWAIT] = !hready && !dphase_vld;
    end
  end

  // stage p1: previous-cycle bus snapshot
  always_ff @(posedge clk) begin
    htrans_p1    <= htrans;
    haddr_p1     <= haddr;
    hwrite_p1    <= hwrite;
    hsize_p1     <= hsize;
    hburst_p1    <= hburst;
    hprot_p1     <= hprot;
    hmastlock_p1 <= hmastlock;
    hready_p1    <= hready;
    hresp_p1     <= hresp;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hist_vld   <= 1'b0;
      dphase_vld <= 1'b0;
      stall_cnt  <= '0;
      err_flags  <= '0;
      xfer_count <= '0;
    end else begin
      hist_vld  <= 1'b1;
      stall_cnt <= stall_now;
      err_flags <= err_flags | err_set;
      if (hready)
        dphase_vld <= active;
      if (dphase_vld && hready && !hresp && (xfer_count != '1))
        xfer_count <= xfer_count + 1'b1;
    end
  end

`ifdef AHBL_CHECKER_FORMAL_EN
`ifdef FORMAL
  always_comb begin
    for (int b = 0; b < W_ERR; b++)
      assert (!err_set[b]);
    assume (!err_set[ERR_RESP1]);
    assume (!err_set[ERR_RESPX]);
    assume (!err_set[ERR_STALL]);
    assume (!err_set[ERR_IDLEWAIT]);
  end
`endif
`else
`endif

endmodule

// File: rtl/ahbl_multiport_checker.sv
// N-port AHB-Lite protocol monitor: per-port checkers, first-error capture and error reduction.
// Define AHBL_CHECKER_FORMAL_EN to emit assert/assume of the violation bits under FORMAL.
module ahbl_multiport_checker
  import ahbl_checker_pkg::*;
#(
  parameter int N_PORTS       = 2,
  parameter int W_ADDR        = 32,
  parameter int W_DATA        = 32,
  parameter int MAX_BUS_STALL = -1,
  parameter int W_CNT         = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  ahbl_multiport_checker_if.slave  bus,
  output logic [N_PORTS*W_ERR-1:0] err_flags,
  output logic                     err_any,
  output logic [2:0]               err_first_port,
  output logic [W_ERR-1:0]         err_first_code,
  output logic [N_PORTS*W_CNT-1:0] xfer_count
);

  logic [W_ERR-1:0] err_set [N_PORTS];
  logic             first_hit;
  logic [2:0]       first_idx;
  logic [W_ERR-1:0] first_code;

  for (genvar p = 0; p < N_PORTS; p++) begin : g_port
    ahbl_port_checker #(
      .W_ADDR        (W_ADDR),
      .W_DATA        (W_DATA),
      .MAX_BUS_STALL (MAX_BUS_STALL),
      .W_CNT         (W_CNT)
    ) u_port (
      .clk        (clk),
      .rst        (rst),
      .haddr      (bus.haddr[p*W_ADDR +: W_ADDR]),
      .hwrite     (bus.hwrite[p]),
      .htrans     (bus.htrans[p*2 +: 2]),
      .hsize      (bus.hsize[p*3 +: 3]),
      .hburst     (bus.hburst[p*3 +: 3]),
      .hprot      (bus.hprot[p*4 +: 4]),
      .hmastlock  (bus.hmastlock[p]),
      .hready     (bus.hready[p]),
      .hresp      (bus.hresp[p]),
      .err_set    (err_set[p]),
      .err_flags  (err_flags[p*W_ERR +: W_ERR]),
      .xfer_count (xfer_count[p*W_CNT +: W_CNT])
    );
  end

  assign err_any = |err_flags;

  // descending scan so the lowest-indexed violating port wins
  always_comb begin
    first_hit  = 1'b0;
    first_idx  = '0;
    first_code = '0;
    for (int p = N_PORTS - 1; p >= 0; p--) begin
      if (err_set[p] != '0) begin
        first_hit  = 1'b1;
        first_idx  = 3'(p);
        first_code = err_set[p];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_first_port <= '0;
      err_first_code <= '0;
    end else if (!err_any && first_hit) begin
      err_first_port <= first_idx;
      err_first_code <= first_code;
    end
  end

endmodule

// File: tb/tb_ahbl_multiport_checker.sv
// Table-driven bench for ahbl_multiport_checker (2 ports, 32-bit data, MAX_BUS_STALL=3).
module tb_ahbl_multiport_checker;
  import ahbl_checker_pkg::*;

  localparam int NP = 2;
  localparam int WA = 32;
  localparam int WD = 32;
  localparam int MS = 3;
  localparam int WC = 16;

  typedef struct packed {
    logic [1:0]  htrans;
    logic [31:0] haddr;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic        hready;
    logic        hresp;
  } port_in_t;

  typedef struct {
    bit          rst;
    port_in_t    p0;
    port_in_t    p1;
    logic [15:0] flags;
    logic [2:0]  fport;
    logic [7:0]  fcode;
    logic [15:0] cnt0;
    logic [15:0] cnt1;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] err_flags;
  logic        err_any;
  logic [2:0]  err_first_port;
  logic [7:0]  err_first_code;
  logic [31:0] xfer_count;

  ahbl_multiport_checker_if #(.N_PORTS(NP), .W_ADDR(WA)) bus ();

  ahbl_multiport_checker #(
    .N_PORTS(NP), .W_ADDR(WA), .W_DATA(WD), .MAX_BUS_STALL(MS), .W_CNT(WC)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .bus            (bus),
    .err_flags      (err_flags),
    .err_any        (err_any),
    .err_first_port (err_first_port),
    .err_first_code (err_first_code),
    .xfer_count     (xfer_count)
  );

  always #5 clk = ~clk;

  int       errors = 0;
  int       checks = 0;
  int       row_id = 0;
  vec_t     vecs[$];
  vec_t     exp_q[$];
  port_in_t pi;
  port_in_t ps;

  function automatic port_in_t pin(logic [1:0] t, logic [31:0] a, logic [2:0] sz,
                                   logic rdy, logic rsp);
    port_in_t p;
    p.htrans = t;
    p.haddr  = a;
    p.hwrite = 1'b0;
    p.hsize  = sz;
    p.hburst = 3'b001;
    p.hready = rdy;
    p.hresp  = rsp;
    return p;
  endfunction

  function automatic vec_t mkv(bit r, port_in_t a, port_in_t b, logic [15:0] f,
                               logic [2:0] fp, logic [7:0] fc, int c0, int c1);
    vec_t v;
    v.rst   = r;
    v.p0    = a;
    v.p1    = b;
    v.flags = f;
    v.fport = fp;
    v.fcode = fc;
    v.cnt0  = 16'(c0);
    v.cnt1  = 16'(c1);
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL row %0d %s: got %0h expected %0h", row_id, name, act, exp);
    end
  endtask

  task automatic drive(vec_t v);
    rst           = v.rst;
    bus.htrans    = {v.p1.htrans, v.p0.htrans};
    bus.haddr     = {v.p1.haddr, v.p0.haddr};
    bus.hwrite    = {v.p1.hwrite, v.p0.hwrite};
    bus.hsize     = {v.p1.hsize, v.p0.hsize};
    bus.hburst    = {v.p1.hburst, v.p0.hburst};
    bus.hprot     = 8'h33;
    bus.hmastlock = 2'b00;
    bus.hready    = {v.p1.hready, v.p0.hready};
    bus.hresp     = {v.p1.hresp, v.p0.hresp};
  endtask

  task automatic step(vec_t v);
    vec_t e;
    drive(v);
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk("err_flags", 32'(err_flags), 32'(e.flags));
    chk("err_any", 32'(err_any), 32'(e.flags != 16'h0));
    chk("err_first_port", 32'(err_first_port), 32'(e.fport));
    chk("err_first_code", 32'(err_first_code), 32'(e.fcode));
    chk("xfer_count0", 32'(xfer_count[15:0]), 32'(e.cnt0));
    chk("xfer_count1", 32'(xfer_count[31:16]), 32'(e.cnt1));
    row_id++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    pi = pin(HTRANS_IDLE, 32'h0, 3'd2, 1'b1, 1'b0);
    drive(mkv(1'b1, pi, pi, 16'h0, 3'd0, 8'h0, 0, 0));

    // reset, plain transfers, OKAY-then-ERROR response, HOLD, reset mid-wait, multi-port errors
    vecs.push_back(mkv(1, pi, pi, 16'h0, 0, 8'h00, 0, 0));
    vecs.push_back(mkv(0, pi, pi, 16'h0, 0, 8'h00, 0, 0));
    vecs.push_back(mkv(0, pin(HTRANS_NSEQ, 32'h1000, 2, 1, 0), pi, 16'h0, 0, 8'h00, 0, 0));
    vecs.push_back(mkv(0, pi, pi, 16'h0, 0, 8'h00, 1, 0));
    vecs.push_back(mkv(0, pin(HTRANS_NSEQ, 32'h1004, 2, 1, 0), pi, 16'h0, 0, 8'h00, 1, 0));
    vecs.push_back(mkv(0, pin(HTRANS_SEQ, 32'h1008, 2, 1, 0), pi, 16'h0, 0, 8'h00, 2, 0));
    vecs.push_back(mkv(0, pi, pi, 16'h0, 0, 8'h00, 3, 0));
    vecs.push_back(mkv(0, pin(HTRANS_NSEQ, 32'h1003, 0, 1, 0), pin(HTRANS_NSEQ, 32'h2002, 1, 1, 0),
                       16'h0, 0, 8'h00, 3, 0));
    vecs.push_back(mkv(0, pi, pi, 16'h0, 0, 8'h00, 4, 1));
    vecs.push_back(mkv(0, pin(HTRANS_NSEQ, 32'h1010, 2, 1, 0), pi, 16'h0, 0, 8'h00, 4, 1));
    vecs.push_back(mkv(0, pin(HTRANS_IDLE, 32'h0, 2, 0, 1), pi, 16'h0, 0, 8'h00, 4, 1));
    vecs.push_back(mkv(0, pin(HTRANS_IDLE, 32'h0, 2, 1, 1), pi, 16'h0, 0, 8'h00, 4, 1));
    vecs.push_back(mkv(0, pi, pi, 16'h0, 0, 8'h00, 4, 1));
    vecs.push_back(mkv(0, pi, pin(HTRANS_NSEQ, 32'h2010, 2, 1, 0), 16'h0, 0, 8'h00, 4, 1));
    vecs.push_back(mkv(0, pi, pin(HTRANS_NSEQ, 32'h2000, 2, 0, 0), 16'h0, 0, 8'h00, 4, 1));
    vecs.push_back(mkv(0, pi, pin(HTRANS_NSEQ, 32'h2004, 2, 1, 0), 16'h0100, 1, 8'h01, 4, 2));
    vecs.push_back(mkv(0, pi, pi, 16'h0100, 1, 8'h01, 4, 3));
    vecs.push_back(mkv(0, pi, pin(HTRANS_NSEQ, 32'h2020, 2, 1, 0), 16'h0100, 1, 8'h01, 4, 3));
    vecs.push_back(mkv(0, pi, pin(HTRANS_NSEQ, 32'h2024, 2, 0, 0), 16'h0100, 1, 8'h01, 4, 3));
    vecs.push_back(mkv(1, pi, pin(HTRANS_NSEQ, 32'h2024, 2, 0, 0), 16'h0, 0, 8'h00, 0, 0));
    vecs.push_back(mkv(0, pi, pin(HTRANS_NSEQ, 32'h2028, 2, 1, 0), 16'h0, 0, 8'h00, 0, 0));
    vecs.push_back(mkv(0, pi, pi, 16'h0, 0, 8'h00, 0, 1));
    vecs.push_back(mkv(0, pin(HTRANS_NSEQ, 32'h1002, 2, 1, 0), pin(HTRANS_NSEQ, 32'h2000, 3, 1, 0),
                       16'h0402, 0, 8'h02, 0, 1));
    vecs.push_back(mkv(0, pi, pi, 16'h0402, 0, 8'h02, 1, 2));
    vecs.push_back(mkv(0, pin(HTRANS_NSEQ, 32'h1000, 2, 1, 0), pi, 16'h0402, 0, 8'h02, 1, 2));
    vecs.push_back(mkv(0, pin(HTRANS_IDLE, 32'h0, 2, 0, 1), pi, 16'h0402, 0, 8'h02, 1, 2));
    vecs.push_back(mkv(0, pin(HTRANS_IDLE, 32'h0, 2, 1, 0), pi, 16'h0412, 0, 8'h02, 2, 2));
    vecs.push_back(mkv(0, pi, pin(HTRANS_IDLE, 32'h0, 2, 1, 1), 16'h2412, 0, 8'h02, 2, 2));
    vecs.push_back(mkv(0, pi, pin(HTRANS_IDLE, 32'h0, 2, 0, 0), 16'hA412, 0, 8'h02, 2, 2));
    ps = pin(HTRANS_SEQ, 32'h2000, 2, 1, 0);
    ps.hburst = HBURST_SINGLE;
    vecs.push_back(mkv(0, pi, ps, 16'hAC12, 0, 8'h02, 2, 2));
    vecs.push_back(mkv(0, pi, pi, 16'hAC12, 0, 8'h02, 2, 3));

    for (int i = 0; i < vecs.size(); i++)
      step(vecs[i]);

    // bounded stall: three wait states are legal, the fourth consecutive one flags
    step(mkv(1, pi, pi, 16'h0, 0, 8'h00, 0, 0));
    step(mkv(0, pi, pi, 16'h0, 0, 8'h00, 0, 0));
    step(mkv(0, pin(HTRANS_NSEQ, 32'h1000, 2, 1, 0), pi, 16'h0, 0, 8'h00, 0, 0));
    for (int k = 0; k < 3; k++)
      step(mkv(0, pin(HTRANS_IDLE, 32'h0, 2, 0, 0), pi, 16'h0, 0, 8'h00, 0, 0));
    step(mkv(0, pi, pi, 16'h0, 0, 8'h00, 1, 0));
    step(mkv(0, pin(HTRANS_NSEQ, 32'h1004, 2, 1, 0), pi, 16'h0, 0, 8'h00, 1, 0));
    for (int k = 0; k < 3; k++)
      step(mkv(0, pin(HTRANS_IDLE, 32'h0, 2, 0, 0), pi, 16'h0, 0, 8'h00, 1, 0));
    step(mkv(0, pin(HTRANS_IDLE, 32'h0, 2, 0, 0), pi, 16'h0040, 0, 8'h40, 1, 0));
    step(mkv(0, pi, pi, 16'h0040, 0, 8'h40, 2, 0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
